// File: rtl/mem_to_axi_bridge.sv
// Bridges a req/gnt/valid memory port onto single-beat AXI4 master transactions.
// One transaction in flight; every AXI-facing output comes straight from a register.
module mem_to_axi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter int AXI_ID     = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      busy_o,

    input  logic                      s_mem_req,
    output logic                      s_mem_gnt,
    input  logic [ADDR_WIDTH-1:0]     s_mem_addr,
    input  logic                      s_mem_we,
    input  logic [DATA_WIDTH/8-1:0]   s_mem_be,
    input  logic [DATA_WIDTH-1:0]     s_mem_wdata,
    output logic                      s_mem_valid,
    output logic [DATA_WIDTH-1:0]     s_mem_rdata,
    output logic                      s_mem_error,

    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic [3:0]                m_axi_awregion,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,

    output logic [ID_WIDTH-1:0]       m_axi_arid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic [3:0]                m_axi_arregion,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,

    input  logic [ID_WIDTH-1:0]       m_axi_rid,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int                  STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]          AXI_SIZE   = 3'($clog2(STRB_WIDTH));
    localparam logic [ID_WIDTH-1:0] ID_VALUE   = ID_WIDTH'(AXI_ID);
    localparam logic [1:0]          RESP_OKAY  = 2'b00;

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] WR_RESP      = 3'd2;
    localparam logic [2:0] RD_ADDR      = 3'd3;
    localparam logic [2:0] RD_DATA      = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] be_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  aw_done;
    logic                  w_done;

    // IDs, rlast and the exclusive-access flavour of the response are not used.
    logic unused_axi_inputs;
    assign unused_axi_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

    assign s_mem_gnt = s_mem_req && (state == IDLE);
    assign busy_o    = (state != IDLE);

    // A channel counts as done once its valid is already low or is being accepted now.
    assign aw_done = !awvalid_q || m_axi_awready;
    assign w_done  = !wvalid_q  || m_axi_wready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            s_mem_valid <= 1'b0;
            s_mem_error <= 1'b0;
            s_mem_rdata <= '0;
        end else begin
            s_mem_valid <= 1'b0;
            s_mem_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_mem_gnt) begin
                        addr_q  <= s_mem_addr;
                        wdata_q <= s_mem_wdata;
                        be_q    <= s_mem_be;
                        if (s_mem_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (m_axi_wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q    <= 1'b0;
                        s_mem_valid <= 1'b1;
                        s_mem_error <= resp_is_error(m_axi_bresp);
                        state       <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        rready_q    <= 1'b0;
                        s_mem_rdata <= m_axi_rdata;
                        s_mem_valid <= 1'b1;
                        s_mem_error <= resp_is_error(m_axi_rresp);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_axi_awid     = ID_VALUE;
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = AXI_SIZE;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = 4'b0000;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_awqos    = 4'd0;
    assign m_axi_awregion = 4'd0;
    assign m_axi_awvalid  = awvalid_q;

    assign m_axi_wdata    = wdata_q;
    assign m_axi_wstrb    = be_q;
    assign m_axi_wlast    = 1'b1;
    assign m_axi_wvalid   = wvalid_q;

    assign m_axi_bready   = bready_q;

    assign m_axi_arid     = ID_VALUE;
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = 8'd0;
    assign m_axi_arsize   = AXI_SIZE;
    assign m_axi_arburst  = 2'b01;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'b0000;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_arvalid  = arvalid_q;

    assign m_axi_rready   = rready_q;

endmodule

// File: tb/tb_mem_to_axi_bridge.sv
// Bench for mem_to_axi_bridge: a delay-programmable AXI slave with its own memory,
// and a word-level memory model that predicts read data, error flags and latency.
`timescale 1ns/1ps
module tb_mem_to_axi_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk_i = 1'b0;
    logic rst_i;
    logic busy_o;
    logic s_mem_req, s_mem_gnt, s_mem_we, s_mem_valid, s_mem_error;
    logic [AW-1:0] s_mem_addr;
    logic [3:0] s_mem_be;
    logic [DW-1:0] s_mem_wdata, s_mem_rdata;
    logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0] m_axi_awlen, m_axi_arlen;
    logic [2:0] m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic m_axi_awlock, m_axi_arlock;
    logic [3:0] m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos, m_axi_awregion, m_axi_arregion;
    logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [3:0] m_axi_wstrb;
    logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic m_axi_rvalid, m_axi_rready, m_axi_rlast;

    always #5 clk_i = ~clk_i;

    mem_to_axi_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .busy_o(busy_o),
        .s_mem_req(s_mem_req), .s_mem_gnt(s_mem_gnt), .s_mem_addr(s_mem_addr),
        .s_mem_we(s_mem_we), .s_mem_be(s_mem_be), .s_mem_wdata(s_mem_wdata),
        .s_mem_valid(s_mem_valid), .s_mem_rdata(s_mem_rdata), .s_mem_error(s_mem_error),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awregion(m_axi_awregion), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_done = 0;

    // Current transaction as the initiator asked for it, plus slave behaviour for it.
    logic exp_we = 1'b0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0, last_rd = '0;
    logic [3:0] exp_be = '0;
    logic exp_err = 1'b0;
    logic [1:0] cfg_resp = 2'b00;
    int cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_b_dly = 0, cfg_r_dly = 0;

    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] slv_mem [logic [29:0]];

    // Constant field bundle {id,len,size,burst,lock,cache,prot,qos,region} for a 32-bit beat.
    localparam logic [30:0] AX_CONST = {2'd0, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [29:0] w);
        return 32'h5A00_0000 ^ {w[15:0], ~w[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        return init_val(a[31:2]);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        if (slv_mem.exists(a[31:2])) return slv_mem[a[31:2]];
        return init_val(a[31:2]);
    endfunction

    // AXI slave: ready after N cycles of valid, response N cycles after the request completes.
    initial begin : slave
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit aw_got, w_got, ar_got, applied;
        logic [31:0] cap_awaddr, cap_araddr, cap_wdata;
        logic [3:0] cap_wstrb;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0; applied = 0;
        cap_awaddr = '0; cap_araddr = '0; cap_wdata = '0; cap_wstrb = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
        m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rid = 0; m_axi_rdata = 0; m_axi_rlast = 1;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; ar_got = 0; applied = 0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0;
            end else begin
                if (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid)
                    chk("no_overlap", (m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid || aw_got || w_got)) ||
                                      ((m_axi_awvalid || m_axi_wvalid) && ar_got), 0);
                if (m_axi_bready) chk("bready_after_aw_w", aw_got && w_got, 1);
                if (m_axi_rready) chk("rready_after_ar", ar_got, 1);
                if (aw_got && w_got) begin
                    if (!applied) begin
                        slv_mem[cap_awaddr[31:2]] = merge(slv_rd(cap_awaddr), cap_wdata, cap_wstrb);
                        applied = 1;
                    end
                    if (b_cnt >= cfg_b_dly) begin
                        m_axi_bvalid = 1; m_axi_bresp = cfg_resp;
                        if (m_axi_bready) begin
                            aw_got = 0; w_got = 0; applied = 0; b_cnt = 0; aw_cnt = 0; w_cnt = 0;
                        end
                    end else begin
                        m_axi_bvalid = 0; b_cnt++;
                    end
                end else m_axi_bvalid = 0;
                if (ar_got) begin
                    if (r_cnt >= cfg_r_dly) begin
                        m_axi_rvalid = 1; m_axi_rresp = cfg_resp; m_axi_rdata = slv_rd(cap_araddr);
                        if (m_axi_rready) begin ar_got = 0; r_cnt = 0; ar_cnt = 0; end
                    end else begin
                        m_axi_rvalid = 0; r_cnt++;
                    end
                end else m_axi_rvalid = 0;
                if (m_axi_awvalid) begin
                    chk("aw_single", aw_got, 0);
                    chk("aw_for_write", exp_we, 1);
                    chk("awaddr", m_axi_awaddr, exp_addr);
                    chk("aw_const", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                                     m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion}, AX_CONST);
                    if (aw_cnt >= cfg_aw_dly) begin
                        m_axi_awready = 1; aw_got = 1; cap_awaddr = m_axi_awaddr;
                    end else begin
                        m_axi_awready = 0; aw_cnt++;
                    end
                end else m_axi_awready = 0;
                if (m_axi_wvalid) begin
                    chk("w_single", w_got, 0);
                    chk("wdata", m_axi_wdata, exp_wdata);
                    chk("wstrb_wlast", {m_axi_wstrb, m_axi_wlast}, {exp_be, 1'b1});
                    if (w_cnt >= cfg_w_dly) begin
                        m_axi_wready = 1; w_got = 1; cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
                    end else begin
                        m_axi_wready = 0; w_cnt++;
                    end
                end else m_axi_wready = 0;
                if (m_axi_arvalid) begin
                    chk("ar_single", ar_got, 0);
                    chk("ar_for_read", exp_we, 0);
                    chk("araddr", m_axi_araddr, exp_addr);
                    chk("ar_const", {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                                     m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion}, AX_CONST);
                    if (ar_cnt >= cfg_ar_dly) begin
                        m_axi_arready = 1; ar_got = 1; cap_araddr = m_axi_araddr;
                    end else begin
                        m_axi_arready = 0; ar_cnt++;
                    end
                end else m_axi_arready = 0;
            end
        end
    end

    initial begin : valid_monitor
        logic prev_v;
        prev_v = 0;
        forever begin
            @(negedge clk_i);
            if (s_mem_valid) begin
                n_valid++;
                chk("valid_single_cycle", prev_v, 0);
            end
            prev_v = s_mem_valid;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Present a request (caller sits at a negedge) and return just after the granting edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [1:0] resp,
                         input int daw, input int dw, input int dar, input int db, input int dr);
        int n = 0;
        s_mem_req = 1; s_mem_we = we; s_mem_addr = addr; s_mem_be = be; s_mem_wdata = wdata;
        #1;
        while (!s_mem_gnt && n < 200) begin
            @(negedge clk_i); #1; n++;
        end
        chk("gnt", s_mem_gnt, 1);
        exp_we = we; exp_addr = addr; exp_be = be; exp_wdata = wdata; exp_err = (resp != 2'b00);
        cfg_resp = resp; cfg_aw_dly = daw; cfg_w_dly = dw; cfg_ar_dly = dar; cfg_b_dly = db; cfg_r_dly = dr;
        if (we) ref_mem[addr[31:2]] = merge(ref_rd(addr), wdata, be);
        else exp_rdata = ref_rd(addr);
        @(posedge clk_i); #1;
    endtask

    task automatic wait_done(output int lat);
        bit seen = 0;
        lat = 0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(negedge clk_i);
            if (s_mem_valid) begin
                seen = 1; lat = i;
            end else begin
                chk("busy_during_txn", busy_o, 1);
                if (s_mem_req) chk("gnt_while_busy", s_mem_gnt, 0);
            end
        end
        chk("completion_seen", seen, 1);
        if (seen) begin
            n_done++;
            chk("busy_at_done", busy_o, 0);
            chk("error", s_mem_error, exp_err);
            if (exp_we) chk("rdata_hold", s_mem_rdata, last_rd);
            else begin
                chk("rdata", s_mem_rdata, exp_rdata);
                last_rd = exp_rdata;
            end
        end
    endtask

    task automatic run(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [1:0] resp,
                       input int daw, input int dw, input int dar, input int db, input int dr);
        int lat;
        int exp_lat;
        issue(we, addr, be, wdata, resp, daw, dw, dar, db, dr);
        s_mem_req = 0;
        wait_done(lat);
        exp_lat = we ? 3 + ((daw > dw) ? daw : dw) + db : 3 + dar + dr;
        chk("latency", lat, exp_lat);
    endtask

    initial begin : main
        int lat;
        int n;
        logic [31:0] a, d;
        logic [3:0] be;
        logic [1:0] resp;
        int r;
        s_mem_req = 0; s_mem_we = 0; s_mem_addr = 0; s_mem_be = 0; s_mem_wdata = 0;
        rst_i = 1;
        #1;
        chk("reset_ctrl", {busy_o, s_mem_gnt, s_mem_valid, s_mem_error, m_axi_awvalid, m_axi_wvalid,
                           m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        chk("reset_rdata", s_mem_rdata, 0);
        chk("reset_latched", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, 0);
        repeat (3) @(negedge clk_i);
        rst_i = 0;
        ref_mem[30'h10] = 32'hDEADBEEF;
        slv_mem[30'h10] = 32'hDEADBEEF;
        @(negedge clk_i);

        // Minimum-latency read against an always-ready slave.
        issue(0, 32'h40, 4'hF, 0, 2'b00, 0, 0, 0, 0, 0);
        s_mem_req = 0;
        @(negedge clk_i);
        chk("t1_arvalid_cycle1", m_axi_arvalid, 1);
        @(negedge clk_i);
        chk("t1_rready_cycle2", m_axi_rready, 1);
        wait_done(lat);
        chk("t1_valid_cycle3", lat, 1);
        chk("t1_rdata", s_mem_rdata, 32'hDEADBEEF);

        // Partial-strobe write, then read it back.
        run(1, 32'h100, 4'b0011, 32'hA5A5A5A5, 2'b00, 0, 0, 0, 0, 0);
        run(0, 32'h100, 4'hF, 0, 2'b00, 0, 0, 0, 0, 0);
        chk("t2_merge", s_mem_rdata, {init_val(30'h40) >> 16, 16'hA5A5});

        // W accepted three cycles after AW.
        run(1, 32'h200, 4'hF, 32'h1234_5678, 2'b00, 0, 3, 0, 0, 0);
        run(1, 32'h204, 4'hC, 32'h9ABC_DEF0, 2'b00, 2, 0, 0, 1, 0);

        // Error responses.
        run(0, 32'h100, 4'hF, 0, 2'b10, 0, 0, 1, 0, 2);
        run(1, 32'h300, 4'hF, 32'hCAFE_F00D, 2'b11, 0, 0, 0, 0, 0);

        // Back-to-back: second request held while the first is outstanding.
        issue(0, 32'h40, 4'hF, 0, 2'b00, 1, 1, 1, 1, 1);
        s_mem_we = 1; s_mem_addr = 32'h304; s_mem_be = 4'hF; s_mem_wdata = 32'h0BAD_F00D;
        wait_done(lat);
        chk("b2b_first_latency", lat, 5);
        chk("b2b_gnt_with_valid", s_mem_gnt, 1);
        issue(1, 32'h304, 4'hF, 32'h0BAD_F00D, 2'b00, 0, 0, 0, 0, 0);
        s_mem_req = 0;
        wait_done(lat);
        chk("b2b_second_latency", lat, 3);

        // Reset while waiting for the write response.
        issue(1, 32'h180, 4'hF, 32'h7777_1111, 2'b00, 0, 0, 0, 30, 0);
        s_mem_req = 0;
        n = 0;
        while (!m_axi_bready && n < 50) begin
            @(negedge clk_i); n++;
        end
        chk("t6_in_wr_resp", {m_axi_bready, busy_o}, 2'b11);
        rst_i = 1;
        #1;
        chk("t6_async_ctrl", {busy_o, s_mem_gnt, s_mem_valid, s_mem_error, m_axi_awvalid, m_axi_wvalid,
                              m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        chk("t6_async_data", {s_mem_rdata, m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, 0);
        last_rd = 0;
        repeat (3) @(negedge clk_i);
        rst_i = 0;
        repeat (4) @(negedge clk_i);
        chk("t6_no_completion", n_valid, n_done);
        run(0, 32'h180, 4'hF, 0, 2'b00, 0, 0, 0, 0, 0);

        // Randomized mix over a small address window so reads hit earlier writes.
        for (int k = 0; k < 40; k++) begin
            a = 32'h1000 + ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 3) == 0) a = a + $urandom_range(1, 3);
            d = $urandom;
            be = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 3);
            resp = (r < 2) ? 2'b00 : 2'(r);
            run(1'($urandom_range(0, 1)), a, be, d, resp,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk_i);
        chk("valid_count", n_valid, n_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_to_axi_bridge.md
Name: mem_to_axi_bridge

Overview:
- Converts the SoC's simple memory request interface (req/gnt/valid) into single-beat AXI4 master transactions.
- Lets mem-style initiators (cores, DMA front-ends) reach AXI slaves on the bus array.
- One transaction in flight; FSM-sequenced; all AXI outputs registered.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data width on both sides; legal values are 32 and 64.
- ID_WIDTH, 2, AXI ID width.
- AXI_ID, 0, constant value driven on awid/arid.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- busy_o  out  1  high whenever state != IDLE.
- s_mem_req  in  1  request valid.
- s_mem_gnt  out  1  request accepted.
- s_mem_addr  in  ADDR_WIDTH  byte address.
- s_mem_we  in  1  1 = write, 0 = read.
- s_mem_be  in  DATA_WIDTH/8  byte enables.
- s_mem_wdata  in  DATA_WIDTH  write data.
- s_mem_valid  out  1  completion pulse; fires for reads and writes.
- s_mem_rdata  out  DATA_WIDTH  read data, qualified by s_mem_valid.
- s_mem_error  out  1  completion had a non-OKAY resp, qualified by s_mem_valid.
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,valid}  out  AXI4 widths  write address channel.
- m_axi_awready  in  1.
- m_axi_w{data,strb,last,valid}  out.
- m_axi_wready  in  1.
- m_axi_b{id,resp,valid}  in.
- m_axi_bready  out  1.
- m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,region,valid}  out  AXI4 widths  read address channel.
- m_axi_arready  in  1.
- m_axi_r{id,data,resp,last,valid}  in.
- m_axi_rready  out  1.

Interface decisions:
- One clock, clk_i.
- Reset rst_i is asynchronous and active-high.

Behaviour:
- Reset: state = IDLE. All valid/ready outputs, s_mem_gnt, s_mem_valid, s_mem_error and busy_o are 0. s_mem_rdata and the latched request are 0.
- Constant AXI fields:
  - len = 0; size = log2(DATA_WIDTH/8); burst = INCR (2'b01).
  - lock = 0; cache = 4'b0000; prot = 3'b000; qos = 0; region = 0.
  - wlast = 1; id = AXI_ID.
- s_mem_gnt = s_mem_req && state == IDLE (combinational). Address, data, be and we are latched on gnt.
- State IDLE:
  - On a read grant, go to RD_ADDR with arvalid = 1 from the next cycle.
  - On a write grant, go to WR_ADDR_DATA with awvalid = wvalid = 1 from the next cycle.
- State WR_ADDR_DATA:
  - awvalid drops after its AW handshake; wvalid drops after its W handshake. The two are tracked independently and may complete in either order or in the same cycle.
  - Once both handshakes are done, go to WR_RESP.
  - A valid, once asserted, stays high until its handshake (AXI stability rule); addr/data/strb are held constant.
- State WR_RESP: bready = 1. On bvalid, go to IDLE; next cycle s_mem_valid = 1 and s_mem_error = (bresp != OKAY).
- State RD_ADDR: arvalid held until arready, then go to RD_DATA.
- State RD_DATA: rready = 1. On rvalid, latch rdata into s_mem_rdata, go to IDLE; next cycle s_mem_valid = 1 and s_mem_error = (rresp != OKAY).
- s_mem_valid is a single-cycle pulse. s_mem_rdata holds its value until the next read completion.
- A new grant may occur in the same cycle as the s_mem_valid pulse (back-to-back issue).
- Minimum latency with always-ready slaves: gnt at cycle 0, AXI handshake at cycle 1, B/R handshake at cycle 2, s_mem_valid at cycle 3.
- bid/rid, rlast and exokay are ignored. SLVERR and DECERR both map to s_mem_error = 1.
- Unaligned addresses pass through unmodified. be maps directly to wstrb.
- s_mem_req while busy: gnt stays 0; the initiator must hold its request.
- Reset mid-transaction: return to IDLE immediately, no s_mem_valid is delivered, and outstanding AXI responses are dropped.

Test Plan:
- Read, always-ready slave returning rdata=0xDEADBEEF, rresp=OKAY -> arvalid at cycle 1, rready at cycle 2, s_mem_valid=1 with rdata=0xDEADBEEF and error=0 at cycle 3.
- Write addr=0x100, wdata=0xA5A5A5A5, be=4'b0011 -> awaddr=0x100, wstrb=0011, wlast=1, len=0, size=2, burst=01; completion pulse with error=0.
- Write with wready delayed 3 cycles after awready -> awvalid drops after its handshake, wvalid held with stable data, bready asserted only after W completes; single s_mem_valid.
- Read returning rresp=SLVERR, and write returning bresp=DECERR -> s_mem_error=1 on each completion pulse.
- Back-to-back: a second req held high during the first transaction -> gnt only in IDLE, second grant coincides with the first s_mem_valid, and no overlapping AXI transactions.
- rst_i asserted while in WR_RESP -> all outputs 0 asynchronously; after release, a fresh read completes normally.
